// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU control unit and datapath: instruction
// opcodes, ALU operation codes and control FSM states.
package cpu_pkg;

  typedef enum logic [4:0] {
    OP_NOP    = 5'd0,
    OP_LOAD   = 5'd1,
    OP_STORE  = 5'd2,
    OP_MOVE   = 5'd3,
    OP_ADD    = 5'd4,
    OP_SUB    = 5'd5,
    OP_AND    = 5'd6,
    OP_OR     = 5'd7,
    OP_BRANCH = 5'd8,
    OP_BZERO  = 5'd9,
    OP_BNZERO = 5'd10,
    OP_BNEG   = 5'd11,
    OP_BNNEG  = 5'd12,
    OP_BOV    = 5'd13,
    OP_BNOV   = 5'd14,
    OP_BUOV   = 5'd15,
    OP_HALT   = 5'd31
  } opcode_e;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } alu_op_e;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_LOAD_IR  = 4'd1,
    S_DECODE   = 4'd2,
    S_LOAD_1   = 4'd3,
    S_LOAD_2   = 4'd4,
    S_STORE_1  = 4'd5,
    S_ALU_EXEC = 4'd6,
    S_BRANCH   = 4'd7,
    S_HALT     = 4'd8
  } state_e;

endpackage

// File: rtl/control_unit.sv
// Multi-cycle CPU control unit: Moore FSM sequencing fetch, decode and
// execute, plus a 2-bit register that captures the ALU operation in DECODE.
module control_unit
  import cpu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] decoded_instruction,
  input  logic       zero,
  input  logic       neg,
  input  logic       unsigned_overflow,
  input  logic       signed_overflow,
  output logic       branch,
  output logic       pc_enable,
  output logic       ir_enable,
  output logic       addr_sel,
  output logic       c_sel,
  output logic       write_reg_enable,
  output logic [1:0] operation,
  output logic       ram_write_enable,
  output logic       halt
);

  state_e  state, state_d;
  alu_op_e op_q, op_d;

  // State and operation registers; reset returns to FETCH at once.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_FETCH;
      op_q  <= ALU_ADD;
    end else begin
      state <= state_d;
      op_q  <= op_d;
    end
  end

  // Next-state decode and Moore outputs from the current state.
  // NOTE: every signal gets a default first so no path leaves one unassigned,
  // which would infer a latch.
  always_comb begin
    state_d          = state;
    op_d             = op_q;
    branch           = 1'b0;
    pc_enable        = 1'b0;
    ir_enable        = 1'b0;
    addr_sel         = 1'b0;
    c_sel            = 1'b0;
    write_reg_enable = 1'b0;
    operation        = 2'b00;
    ram_write_enable = 1'b0;
    halt             = 1'b0;

    case (state)
      S_FETCH: begin
        // RAM reads at PC; the word arrives for LOAD_IR.
        state_d = S_LOAD_IR;
      end
      S_LOAD_IR: begin
        ir_enable = 1'b1;
        pc_enable = 1'b1;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        state_d = S_FETCH;
        case (opcode_e'(decoded_instruction))
          OP_LOAD:   state_d = S_LOAD_1;
          OP_STORE:  state_d = S_STORE_1;
          OP_ADD:    begin state_d = S_ALU_EXEC; op_d = ALU_ADD; end
          OP_SUB:    begin state_d = S_ALU_EXEC; op_d = ALU_SUB; end
          OP_AND:    begin state_d = S_ALU_EXEC; op_d = ALU_AND; end
          OP_OR:     begin state_d = S_ALU_EXEC; op_d = ALU_OR;  end
          // MOVE is carried out by the ALU as an OR.
          OP_MOVE:   begin state_d = S_ALU_EXEC; op_d = ALU_OR;  end
          OP_BRANCH: state_d = S_BRANCH;
          OP_BZERO:  if (zero)               state_d = S_BRANCH;
          OP_BNZERO: if (!zero)              state_d = S_BRANCH;
          OP_BNEG:   if (neg)                state_d = S_BRANCH;
          OP_BNNEG:  if (!neg)               state_d = S_BRANCH;
          OP_BOV:    if (signed_overflow)    state_d = S_BRANCH;
          OP_BNOV:   if (!signed_overflow)   state_d = S_BRANCH;
          OP_BUOV:   if (unsigned_overflow)  state_d = S_BRANCH;
          OP_HALT:   state_d = S_HALT;
          default:   state_d = S_FETCH;
        endcase
      end
      S_LOAD_1: begin
        addr_sel = 1'b1;
        state_d  = S_LOAD_2;
      end
      S_LOAD_2: begin
        addr_sel         = 1'b1;
        c_sel            = 1'b0;
        write_reg_enable = 1'b1;
        state_d          = S_FETCH;
      end
      S_STORE_1: begin
        addr_sel         = 1'b1;
        ram_write_enable = 1'b1;
        state_d          = S_FETCH;
      end
      S_ALU_EXEC: begin
        c_sel            = 1'b1;
        write_reg_enable = 1'b1;
        operation        = op_q;
        state_d          = S_FETCH;
      end
      S_BRANCH: begin
        branch    = 1'b1;
        pc_enable = 1'b1;
        addr_sel  = 1'b1;
        state_d   = S_FETCH;
      end
      S_HALT: begin
        halt    = 1'b1;
        state_d = S_HALT;
      end
      default: state_d = S_FETCH;
    endcase
  end

endmodule
